// File: rtl/keccak_pkg.sv
// Shared constants, FSM encoding and byte-mask helper for the keccak message feeder.
package keccak_pkg;

  localparam int unsigned RATE_BITS       = 576;
  localparam int unsigned WORD_BITS       = 64;
  localparam int unsigned DIGEST_BITS     = 512;
  localparam int unsigned RATE_BYTES      = 72;
  localparam int unsigned WORDS_PER_BLOCK = 9;
  localparam int unsigned WORD_BYTES      = 8;

  typedef enum logic [2:0] {
    StFill,
    StSendFull,
    StSendLast,
    StWaitDig,
    StHold
  } state_e;

  // Keeps the leading nbytes bytes of a left-aligned word; nbytes >= 8 keeps all.
  function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[63-8*i -: 8] = (i < 32'(nbytes)) ? 8'hff : 8'h00;
    end
    return mask;
  endfunction

endpackage

// File: rtl/keccak_msg_feeder_block_packer.sv
// Rate-block buffer: packs left-aligned 64-bit words into a 576-bit block, zeroing
// bytes past the valid count.
module block_packer
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [63:0]          wr_data,
  input  logic [3:0]           wr_bytes,
  output logic [RATE_BITS-1:0] block,
  output logic [3:0]           word_cnt
);

  logic [RATE_BITS-1:0] block_q;
  logic [3:0]           cnt_q;
  logic [63:0]          word_masked;

  assign word_masked = wr_data & byte_mask(wr_bytes);
  assign block       = block_q;
  assign word_cnt    = cnt_q;

  // Store the masked word in slot word_cnt (word 0 at the top); clear wins over write.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      block_q <= '0;
      cnt_q   <= '0;
    end else if (wr_en && (cnt_q < 4'(WORDS_PER_BLOCK))) begin
      for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
        if (cnt_q == 4'(k)) begin
          block_q[RATE_BITS-1-WORD_BITS*k -: WORD_BITS] <= word_masked;
        end
      end
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/keccak_msg_feeder.sv
// Upstream driver for the keccak core: packs a 64-bit word stream into rate blocks,
// runs the core input handshake and holds the digest until acknowledged.
module keccak_msg_feeder
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_BITS   = 576,
  parameter int unsigned WORD_BITS   = 64,
  parameter int unsigned DIGEST_BITS = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_BITS-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  input  logic [3:0]             s_bytes,
  output logic                   s_ready,
  output logic [RATE_BITS-1:0]   k_in,
  output logic                   k_in_ready,
  output logic                   k_is_last,
  output logic [9:0]             k_byte_num,
  input  logic                   k_buffer_full,
  input  logic [DIGEST_BITS-1:0] k_out,
  input  logic                   k_out_ready,
  output logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_valid,
  input  logic                   digest_ack
);

  state_e                 state_q, state_d;
  logic                   pend_q, pend_d;    // message ended on a block boundary
  logic [6:0]             bn_q, bn_d;        // byte count of the last block
  logic [DIGEST_BITS-1:0] digest_q;

  logic       xfer;
  logic       accept;
  logic [3:0] bytes_eff;
  logic [3:0] wr_bytes;
  logic [3:0] word_cnt;
  logic [6:0] total;

  assign bytes_eff = (s_bytes > 4'd8) ? 4'd8 : s_bytes;
  assign wr_bytes  = s_last ? bytes_eff : 4'd8;
  assign total     = {word_cnt, 3'b000} + {3'b000, bytes_eff};

  assign s_ready    = !reset && (state_q == StFill) && (word_cnt < 4'(WORDS_PER_BLOCK));
  assign xfer       = s_valid && s_ready;
  assign k_in_ready = ((state_q == StSendFull) || (state_q == StSendLast)) && !k_buffer_full;
  assign accept     = k_in_ready;

  assign k_is_last    = (state_q == StSendLast);
  assign k_byte_num   = (state_q == StSendFull) ? 10'(RATE_BYTES) :
                        (state_q == StSendLast) ? {3'b000, bn_q} : 10'd0;
  assign digest       = digest_q;
  assign digest_valid = (state_q == StHold);

  block_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .wr_en    (xfer),
    .wr_data  (s_data),
    .wr_bytes (wr_bytes),
    .block    (k_in),
    .word_cnt (word_cnt)
  );

  // FSM state, pending-empty flag and last-block byte count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFill;
      pend_q  <= 1'b0;
      bn_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bn_q    <= bn_d;
    end
  end

  // Digest capture; stays put through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      digest_q <= '0;
    end else if ((state_q == StWaitDig) && k_out_ready) begin
      digest_q <= k_out;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    bn_d    = bn_q;
    unique case (state_q)
      StFill: begin
        if (xfer) begin
          if (s_last) begin
            if (total == 7'(RATE_BYTES)) begin
              state_d = StSendFull;
              pend_d  = 1'b1;
            end else begin
              state_d = StSendLast;
              bn_d    = total;
            end
          end else if (word_cnt == 4'(WORDS_PER_BLOCK - 1)) begin
            state_d = StSendFull;
            pend_d  = 1'b0;
          end
        end
      end
      StSendFull: begin
        if (accept) begin
          if (pend_q) begin
            state_d = StSendLast;
            bn_d    = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = StFill;
          end
        end
      end
      StSendLast: begin
        if (accept) state_d = StWaitDig;
      end
      StWaitDig: begin
        if (k_out_ready) state_d = StHold;
      end
      StHold: begin
        if (digest_ack) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Self-checking bench: table of messages with a byte-level block model and a
// behavioural core stand-in, plus stall and mid-message reset sequences.
module tb_keccak_msg_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic [3:0]   s_bytes;
  logic         s_ready;
  logic [575:0] k_in;
  logic         k_in_ready;
  logic         k_is_last;
  logic [9:0]   k_byte_num;
  logic         k_buffer_full;
  logic [511:0] k_out;
  logic         k_out_ready;
  logic [511:0] digest;
  logic         digest_valid;
  logic         digest_ack;

  always #5 clk = ~clk;

  keccak_msg_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_bytes       (s_bytes),
    .s_ready       (s_ready),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_byte_num    (k_byte_num),
    .k_buffer_full (k_buffer_full),
    .k_out         (k_out),
    .k_out_ready   (k_out_ready),
    .digest        (digest),
    .digest_valid  (digest_valid),
    .digest_ack    (digest_ack)
  );

  typedef struct {
    logic [575:0] data;
    logic         last;
    logic [9:0]   bn;
  } acc_t;

  typedef struct {
    int nbytes;
    bit bubbles;
    bit bf_rand;
    int exp_blocks;
    int exp_last_bn;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  acc_t         acc_q[$];
  acc_t         exp_q[$];
  logic [7:0]   msg[$];
  bit           bf_force = 1'b0;
  bit           bf_rand  = 1'b0;
  int           dig_cd   = 0;
  logic [511:0] exp_digest = '0;
  longint       pulse_time = 0;
  vec_t         vecs[10];

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Core stand-in: drive buffer_full / out at negedge, log acceptances just after.
  always @(negedge clk) begin
    k_buffer_full = bf_force || (bf_rand && ($urandom_range(0, 2) == 0));
    k_out         = rand512();
    k_out_ready   = 1'b0;
    if (reset) begin
      dig_cd = 0;
    end else if (dig_cd == 1) begin
      k_out_ready = 1'b1;
      exp_digest  = k_out;
      pulse_time  = longint'($time);
      dig_cd      = 0;
    end else if (dig_cd > 1) begin
      dig_cd--;
    end
    #1;
    if (!reset && k_in_ready) begin
      acc_q.push_back('{k_in, k_is_last, k_byte_num});
      if (k_is_last) dig_cd = $urandom_range(1, 4);
    end
  end

  always @(posedge clk) begin
    if (!reset && s_valid && s_ready && s_last)
      assert (s_bytes <= 4'd8) else $error("illegal s_bytes %0d", s_bytes);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic gen_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Expected core blocks straight from the byte string: 72-byte chunks, then a last one.
  task automatic build_expected(input int n);
    logic [575:0] blk;
    int nfull, rem;
    exp_q.delete();
    nfull = n / 72;
    rem   = n % 72;
    for (int b = 0; b < nfull; b++) begin
      blk = '0;
      for (int j = 0; j < 72; j++) blk[575-8*j -: 8] = msg[72*b+j];
      exp_q.push_back('{blk, 1'b0, 10'd72});
    end
    blk = '0;
    for (int j = 0; j < rem; j++) blk[575-8*j -: 8] = msg[72*nfull+j];
    exp_q.push_back('{blk, 1'b1, 10'(rem)});
  endtask

  task automatic send_msg(input int n, input bit bubbles);
    int nw;
    int t;
    logic [63:0] d;
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 8; i++) begin
        d[63-8*i -: 8] = (8*w + i < n) ? msg[8*w+i] : 8'($urandom);
      end
      if (bubbles && ($urandom_range(0, 3) == 0)) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (w == nw - 1);
      s_bytes = s_last ? 4'(n - 8*w) : 4'($urandom_range(0, 15));
      t = 0;
      while (!s_ready && t < 300) begin
        tick();
        t++;
      end
      check("s_ready_wait", 576'(s_ready), 576'(1'b1));
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait for the digest, then compare blocks, digest, latency, hold and release.
  task automatic finish_msg(input string tag, input int exp_blocks, input int exp_last_bn);
    int t;
    int hold;
    bit stable;
    logic [511:0] held;
    t = 0;
    while (!digest_valid && t < 1000) begin
      tick();
      t++;
    end
    check({tag, "_digest_valid"}, 576'(digest_valid), 576'(1'b1));
    check({tag, "_latency"}, 576'(longint'($time) - pulse_time), 576'(12));
    check({tag, "_nblocks_model"}, 576'(acc_q.size()), 576'(exp_q.size()));
    check({tag, "_nblocks_table"}, 576'(acc_q.size()), 576'(exp_blocks));
    check({tag, "_last_bn_table"}, 576'(exp_q[exp_q.size()-1].bn), 576'(exp_last_bn));
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_blk%0d_data", tag, i), acc_q[i].data, exp_q[i].data);
      check($sformatf("%s_blk%0d_last", tag, i), 576'(acc_q[i].last), 576'(exp_q[i].last));
      check($sformatf("%s_blk%0d_bn", tag, i), 576'(acc_q[i].bn), 576'(exp_q[i].bn));
    end
    check({tag, "_digest"}, 576'(digest), 576'(exp_digest));
    check({tag, "_s_ready_hold"}, 576'(s_ready), 576'(1'b0));
    held   = digest;
    stable = 1'b1;
    hold   = $urandom_range(0, 4);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!digest_valid || digest !== held) stable = 1'b0;
    end
    check({tag, "_hold_stable"}, 576'(stable), 576'(1'b1));
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    check({tag, "_valid_cleared"}, 576'(digest_valid), 576'(1'b0));
    check({tag, "_s_ready_after"}, 576'(s_ready), 576'(1'b1));
  endtask

  task automatic run_msg(input string tag, input vec_t v);
    gen_msg(v.nbytes);
    build_expected(v.nbytes);
    acc_q.delete();
    bf_rand = v.bf_rand;
    send_msg(v.nbytes, v.bubbles);
    finish_msg(tag, v.exp_blocks, v.exp_last_bn);
    bf_rand = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 576'(s_ready), 576'(1'b0));
    check({tag, "_k_in"}, k_in, 576'(0));
    check({tag, "_k_in_ready"}, 576'(k_in_ready), 576'(1'b0));
    check({tag, "_k_is_last"}, 576'(k_is_last), 576'(1'b0));
    check({tag, "_k_byte_num"}, 576'(k_byte_num), 576'(0));
    check({tag, "_digest"}, 576'(digest), 576'(0));
    check({tag, "_digest_valid"}, 576'(digest_valid), 576'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit stall_ok;
    vecs[0] = '{64,  0, 0, 1, 64};
    vecs[1] = '{0,   0, 0, 1, 0};
    vecs[2] = '{72,  1, 0, 2, 0};
    vecs[3] = '{100, 1, 1, 2, 28};
    vecs[4] = '{8,   0, 1, 1, 8};
    vecs[5] = '{71,  1, 1, 1, 71};
    vecs[6] = '{144, 1, 1, 3, 0};
    vecs[7] = '{143, 0, 1, 2, 71};
    vecs[8] = '{1,   1, 0, 1, 1};
    vecs[9] = '{80,  1, 1, 2, 8};

    reset      = 1'b1;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    s_bytes    = '0;
    s_data     = '0;
    digest_ack = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b0;
    tick();
    check("por_s_ready_idle", 576'(s_ready), 576'(1'b1));

    for (int i = 0; i < 10; i++) run_msg($sformatf("vec%0d", i), vecs[i]);

    // Stall a full block for 20 cycles, then let it through.
    gen_msg(72);
    build_expected(72);
    acc_q.delete();
    bf_force = 1'b1;
    send_msg(72, 1'b0);
    stall_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (k_in_ready !== 1'b0 || s_ready !== 1'b0 || k_in !== exp_q[0].data ||
          k_is_last !== 1'b0 || k_byte_num !== 10'd72) stall_ok = 1'b0;
      tick();
    end
    check("stall_held", 576'(stall_ok), 576'(1'b1));
    check("stall_no_accept", 576'(acc_q.size()), 576'(0));
    bf_force = 1'b0;
    finish_msg("stall", 2, 0);

    // Reset while a last block is stuck in the core handshake.
    gen_msg(64);
    acc_q.delete();
    bf_force = 1'b1;
    send_msg(64, 1'b0);
    repeat (3) tick();
    check("pre_reset_is_last", 576'(k_is_last), 576'(1'b1));
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset    = 1'b0;
    bf_force = 1'b0;
    tick();
    check("midrst_s_ready", 576'(s_ready), 576'(1'b1));
    check("midrst_no_accept", 576'(acc_q.size()), 576'(0));
    run_msg("post_reset", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
